// File: rtl/decoded_instr_queue.sv
// Decoded-instruction FIFO between decoder and issue: head visible the cycle after push, no bypass.
// Backpressure: in_ready_o drops when full, on flush, or when a CF entry would exceed the CF cap.
module decoded_instr_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int MAX_CF = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_data_i,
    input  logic                         in_cf_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_data_o,
    output logic                         out_cf_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(MAX_CF+1)-1:0]  cf_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int CF_W  = $clog2(MAX_CF+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              cf_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CF_W-1:0]   cf_count_q, cf_count_d;
    logic              push, pop, push_cf, pop_cf;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o  = !flush_i && (count_q < CNT_W'(DEPTH))
                         && !(in_cf_i && (cf_count_q == CF_W'(MAX_CF)));
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_cf_o    = cf_q[rd_ptr_q];
    assign count_o     = count_q;
    assign cf_count_o  = cf_count_q;

    assign push    = in_valid_i && in_ready_o;
    assign pop     = out_valid_o && out_ready_i;
    assign push_cf = push && in_cf_i;
    assign pop_cf  = pop && out_cf_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cf_count_d = cf_count_q;
        // Flush overrides any pop; push is already blocked through in_ready_o.
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            cf_count_d = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (push_cf && !pop_cf)      cf_count_d = cf_count_q + CF_W'(1);
            else if (pop_cf && !push_cf) cf_count_d = cf_count_q - CF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cf_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                cf_q[i]  <= 1'b0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cf_count_q <= cf_count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                cf_q[wr_ptr_q]  <= in_cf_i;
            end
        end
    end

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench: table of per-cycle vectors on a DEPTH=4/MAX_CF=2 queue, plus
// hand sequences for mid-run reset, the CF cap, and wrap-around on a DEPTH=3 queue.
module tb_decoded_instr_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, in_valid_i, in_cf_i, out_ready_i;
    logic [63:0] in_data_i;
    logic        in_ready_o, out_valid_o, out_cf_o;
    logic [63:0] out_data_o;
    logic [2:0]  count_o;
    logic [1:0]  cf_count_o;

    logic        w_flush, w_in_valid, w_in_cf, w_out_ready;
    logic [7:0]  w_in_data;
    logic        w_in_ready, w_out_valid, w_out_cf;
    logic [7:0]  w_out_data;
    logic [1:0]  w_count;
    logic        w_cf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoded_instr_queue #(.DATA_W(64), .DEPTH(4), .MAX_CF(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_cf_i(in_cf_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_cf_o(out_cf_o),
        .count_o(count_o), .cf_count_o(cf_count_o)
    );

    decoded_instr_queue #(.DATA_W(8), .DEPTH(3), .MAX_CF(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush_i(w_flush),
        .in_valid_i(w_in_valid), .in_ready_o(w_in_ready), .in_data_i(w_in_data), .in_cf_i(w_in_cf),
        .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .out_data_o(w_out_data), .out_cf_o(w_out_cf),
        .count_o(w_count), .cf_count_o(w_cf_count)
    );

    typedef struct {
        logic        fl, iv;
        logic [63:0] id;
        logic        ic, orr;
        logic        e_ir, e_ov;
        logic [63:0] e_od;
        logic        e_oc;
        logic [2:0]  e_cnt;
        logic [1:0]  e_cfc;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, iv, input logic [63:0] id, input logic ic, orr,
                                input logic e_ir, e_ov, input logic [63:0] e_od, input logic e_oc,
                                input logic [2:0] e_cnt, input logic [1:0] e_cfc);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.orr = orr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc;
        v.e_cnt = e_cnt; v.e_cfc = e_cfc;
        return v;
    endfunction

    task automatic drive(input logic fl, iv, input logic [63:0] id, input logic ic, orr);
        flush_i = fl; in_valid_i = iv; in_data_i = id; in_cf_i = ic; out_ready_i = orr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx, exp_w, cyc;
        // fill, drain, CF cap, full+simultaneous, flush, push after flush
        //            fl iv  id      ic or   ir ov od      oc cnt cfc
        vecs[0]  = mk(0, 1, 64'h11, 0, 0,   1, 0, 64'h0,  0, 0, 0);
        vecs[1]  = mk(0, 1, 64'h22, 0, 0,   1, 1, 64'h11, 0, 1, 0);
        vecs[2]  = mk(0, 1, 64'h33, 0, 0,   1, 1, 64'h11, 0, 2, 0);
        vecs[3]  = mk(0, 1, 64'h44, 0, 0,   1, 1, 64'h11, 0, 3, 0);
        vecs[4]  = mk(0, 1, 64'h55, 0, 0,   0, 1, 64'h11, 0, 4, 0);
        vecs[5]  = mk(0, 0, 64'h0,  0, 1,   0, 1, 64'h11, 0, 4, 0);
        vecs[6]  = mk(0, 0, 64'h0,  0, 1,   1, 1, 64'h22, 0, 3, 0);
        vecs[7]  = mk(0, 0, 64'h0,  0, 1,   1, 1, 64'h33, 0, 2, 0);
        vecs[8]  = mk(0, 0, 64'h0,  0, 1,   1, 1, 64'h44, 0, 1, 0);
        vecs[9]  = mk(0, 0, 64'h0,  0, 0,   1, 0, 64'h0,  0, 0, 0);
        vecs[10] = mk(0, 1, 64'hA1, 1, 0,   1, 0, 64'h0,  0, 0, 0);
        vecs[11] = mk(0, 1, 64'hA2, 1, 0,   1, 1, 64'hA1, 1, 1, 1);
        vecs[12] = mk(0, 1, 64'hA3, 1, 0,   0, 1, 64'hA1, 1, 2, 2);
        vecs[13] = mk(0, 1, 64'hB1, 0, 0,   1, 1, 64'hA1, 1, 2, 2);
        vecs[14] = mk(0, 0, 64'h0,  0, 1,   1, 1, 64'hA1, 1, 3, 2);
        vecs[15] = mk(0, 1, 64'hA3, 1, 0,   1, 1, 64'hA2, 1, 2, 1);
        vecs[16] = mk(0, 1, 64'hC1, 0, 0,   1, 1, 64'hA2, 1, 3, 2);
        vecs[17] = mk(0, 1, 64'hC2, 0, 1,   0, 1, 64'hA2, 1, 4, 2);
        vecs[18] = mk(0, 1, 64'hC2, 0, 0,   1, 1, 64'hB1, 0, 3, 1);
        vecs[19] = mk(0, 0, 64'h0,  0, 0,   0, 1, 64'hB1, 0, 4, 1);
        vecs[20] = mk(0, 0, 64'h0,  0, 1,   0, 1, 64'hB1, 0, 4, 1);
        vecs[21] = mk(1, 1, 64'hD1, 0, 1,   0, 1, 64'hA3, 1, 3, 1);
        vecs[22] = mk(0, 1, 64'h55, 0, 0,   1, 0, 64'h0,  0, 0, 0);
        vecs[23] = mk(0, 0, 64'h0,  0, 0,   1, 1, 64'h55, 0, 1, 0);
        vecs[24] = mk(0, 1, 64'h66, 0, 0,   1, 1, 64'h55, 0, 1, 0);

        rst_n = 1'b0;
        drive(0, 0, 64'h0, 0, 0);
        w_flush = 0; w_in_valid = 0; w_in_data = '0; w_in_cf = 0; w_out_ready = 0;
        repeat (2) next_cycle();
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst in_ready", in_ready_o, 1);
        chk("rst out_valid", out_valid_o, 0);
        chk("rst out_data", out_data_o, 0);
        chk("rst out_cf", out_cf_o, 0);
        chk("rst count", count_o, 0);
        chk("rst cf_count", cf_count_o, 0);
        next_cycle();

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].orr);
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), in_ready_o, vecs[i].e_ir);
            chk($sformatf("v%0d out_valid", i), out_valid_o, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d out_data", i), out_data_o, vecs[i].e_od);
                chk($sformatf("v%0d out_cf", i), out_cf_o, vecs[i].e_oc);
            end
            chk($sformatf("v%0d count", i), count_o, vecs[i].e_cnt);
            chk($sformatf("v%0d cf_count", i), cf_count_o, vecs[i].e_cfc);
            next_cycle();
        end

        // Reset with 0x55, 0x66 queued
        chk("pre-reset count", count_o, 2);
        drive(0, 0, 64'h0, 0, 0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid-rst out_valid", out_valid_o, 0);
        chk("mid-rst out_data", out_data_o, 0);
        chk("mid-rst out_cf", out_cf_o, 0);
        chk("mid-rst count", count_o, 0);
        chk("mid-rst cf_count", cf_count_o, 0);
        chk("mid-rst in_ready", in_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(0, 0, 64'h0, 0, 1);
            @(negedge clk);
            chk("post-rst no stale valid", out_valid_o, 0);
        end
        next_cycle();

        // CF cap: refused CF and accepted non-CF within the same cycle
        drive(0, 1, 64'hE1, 1, 0);
        next_cycle();
        drive(0, 1, 64'hE2, 1, 0);
        next_cycle();
        drive(0, 1, 64'hE3, 1, 0);
        @(negedge clk);
        chk("cap cf_count", cf_count_o, 2);
        chk("cap cf refused", in_ready_o, 0);
        drive(0, 1, 64'hF1, 0, 0);
        #1;
        chk("cap noncf accepted", in_ready_o, 1);
        next_cycle();
        drive(0, 0, 64'h0, 0, 1);
        @(negedge clk);
        chk("cap count", count_o, 3);
        chk("cap head cf", out_cf_o, 1);
        chk("cap head data", out_data_o, 64'hE1);
        next_cycle();
        drive(0, 1, 64'hE3, 1, 0);
        @(negedge clk);
        chk("cap cf_count after pop", cf_count_o, 1);
        chk("cap cf accepted", in_ready_o, 1);
        next_cycle();
        drive(0, 0, 64'h0, 0, 0);
        @(negedge clk);
        chk("cap cf_count refill", cf_count_o, 2);
        chk("cap count refill", count_o, 3);
        next_cycle();

        // Wrap-around on the DEPTH=3 queue: 10 entries streamed through
        idx = 0; exp_w = 0; cyc = 0;
        w_out_ready = 1;
        while (exp_w < 10 && cyc < 60) begin
            w_in_valid = (idx < 10);
            w_in_data  = 8'(idx);
            @(negedge clk);
            if (w_out_valid && w_out_ready) begin
                chk($sformatf("wrap out %0d", exp_w), w_out_data, 64'(exp_w));
                exp_w++;
            end
            if (w_in_valid && w_in_ready) idx++;
            next_cycle();
            cyc++;
        end
        w_in_valid = 0;
        chk("wrap all drained", 64'(exp_w), 10);
        @(negedge clk);
        chk("wrap empty", w_out_valid, 0);
        chk("wrap count", w_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
